// File: rtl/id_ex_control_pkg.sv
// Shared definitions for the ID/EX control slice: control-word bit positions,
// forward-select and halt-FSM encodings, RV32I opcodes, and a register-write
// match helper used by the hazard logic.
package id_ex_control_pkg;

    localparam int CTRL_W = 10;
    localparam int REG_W  = 5;

    // Control word layout, MSB first:
    // {wb_enable, mem_enable, mem_write, op1_pc, op2_imm, is_ecall,
    //  rs2_used, ex_forwardable, is_branch, is_rd_to_pc}
    localparam int CTRL_WB_ENABLE     = 9;
    localparam int CTRL_MEM_ENABLE    = 8;
    localparam int CTRL_MEM_WRITE     = 7;
    localparam int CTRL_OP1_PC        = 6;
    localparam int CTRL_OP2_IMM       = 5;
    localparam int CTRL_IS_ECALL      = 4;
    localparam int CTRL_RS2_USED      = 3;
    localparam int CTRL_EX_FORWARDABLE = 2;
    localparam int CTRL_IS_BRANCH     = 1;
    localparam int CTRL_IS_RD_TO_PC   = 0;

    // Operand source selects seen by EX
    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // Halt sequencing states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } halt_state_e;

    // Two drain cycles: counter values 0 and 1, leave DRAIN after value 1
    localparam logic [1:0] DRAIN_LAST = 2'd1;

    // ECALL inspects a7 (x17) to decide on halt, so it reads it as rs1
    localparam logic [REG_W-1:0] ECALL_ARG_REG = 5'd17;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // A stage produces register r only if it is live, writes back, and r is not x0
    function automatic logic writes_reg(input logic             valid,
                                        input logic             wb,
                                        input logic [REG_W-1:0] rd,
                                        input logic [REG_W-1:0] r);
        return valid & wb & (rd != '0) & (rd == r);
    endfunction

endpackage

// File: rtl/id_ex_control_hazard.sv
// hazard_detect: load-use detection and operand forward-select generation.
// Latency: purely combinational.
// Backpressure: none; load_use is consumed by id_ex_control to stall ID.
// Ports: ID source info in, EX/MEM producer info in, load_use and fwd selects out.
module hazard_detect
    import id_ex_control_pkg::*;
(
    input  logic             id_valid,
    input  logic             id_op1_pc,
    input  logic             id_is_ecall,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             ex_valid,
    input  logic             ex_wb,
    input  logic             ex_fwdable,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_valid,
    input  logic             mem_wb,
    input  logic [REG_W-1:0] mem_rd,
    output logic             load_use,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    logic [REG_W-1:0] src_a;
    logic             use_a;
    logic             use_b;
    logic             ex_hit_a;
    logic             ex_hit_b;
    logic             mem_hit_a;
    logic             mem_hit_b;

    // ECALL substitutes x17 for the operand-A register
    assign src_a = id_is_ecall ? ECALL_ARG_REG : id_rs1;
    assign use_a = id_valid & (~id_op1_pc | id_is_ecall);
    assign use_b = id_valid & id_rs2_used;

    assign ex_hit_a  = use_a & writes_reg(ex_valid,  ex_wb,  ex_rd,  src_a);
    assign ex_hit_b  = use_b & writes_reg(ex_valid,  ex_wb,  ex_rd,  id_rs2);
    assign mem_hit_a = use_a & writes_reg(mem_valid, mem_wb, mem_rd, src_a);
    assign mem_hit_b = use_b & writes_reg(mem_valid, mem_wb, mem_rd, id_rs2);

    // EX result not ready until after MEM (e.g. a load): the consumer must wait
    assign load_use = (ex_hit_a | ex_hit_b) & ~ex_fwdable;

    // The younger producer (current EX, next cycle in MEM) wins over MEM
    assign fwd_a = ex_hit_a ? FWD_MEM : (mem_hit_a ? FWD_WB : FWD_RF);
    assign fwd_b = ex_hit_b ? FWD_MEM : (mem_hit_b ? FWD_WB : FWD_RF);

endmodule

// File: rtl/id_ex_control.sv
// id_ex_control: ID->EX issue register, MEM/WB tracking, hazard stall/flush and halt FSM.
// Latency: 1 cycle ID->EX for control, rd and forward selects; stall/flush are combinational.
// Backpressure: stall holds PC and IF/ID on load-use and in DRAIN/HALTED; redirect flushes.
// Ports: clk/reset(active-low async), ID instruction in, EX redirect/halt in,
//        stall/flush to front end, registered EX control/rd/valid/fwd selects, halted.
module id_ex_control
    import id_ex_control_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic [REG_W-1:0]  id_rd,
    input  logic              ex_redirect,
    input  logic              ex_halt_req,
    output logic              stall,
    output logic              flush_if_id,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [REG_W-1:0]  ex_rd,
    output logic              ex_valid,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted
);

    halt_state_e      state;
    halt_state_e      state_d;
    logic [1:0]       drain_cnt;

    logic             mem_valid;
    logic             mem_wb;
    logic [REG_W-1:0] mem_rd;
    logic             wb_valid;
    logic             wb_wb;
    logic [REG_W-1:0] wb_rd;

    logic             load_use;
    logic [1:0]       hd_fwd_a;
    logic [1:0]       hd_fwd_b;
    logic             running;
    logic             halt_go;
    logic             redirect_go;
    logic             issue;
    logic             pending_write;

    hazard_detect u_hazard (
        .id_valid    (id_valid),
        .id_op1_pc   (id_ctrl[CTRL_OP1_PC]),
        .id_is_ecall (id_ctrl[CTRL_IS_ECALL]),
        .id_rs2_used (id_ctrl[CTRL_RS2_USED]),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_valid    (ex_valid),
        .ex_wb       (ex_ctrl[CTRL_WB_ENABLE]),
        .ex_fwdable  (ex_ctrl[CTRL_EX_FORWARDABLE]),
        .ex_rd       (ex_rd),
        .mem_valid   (mem_valid),
        .mem_wb      (mem_wb),
        .mem_rd      (mem_rd),
        .load_use    (load_use),
        .fwd_a       (hd_fwd_a),
        .fwd_b       (hd_fwd_b)
    );

    // Redirect and halt requests only matter while running
    assign running     = (state == ST_RUN);
    assign halt_go     = running & ex_valid & ex_ctrl[CTRL_IS_ECALL] & ex_halt_req;
    assign redirect_go = running & ex_redirect;
    assign issue       = running & ~halt_go & ~redirect_go & ~load_use & id_valid;

    // State register and drain counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_RUN;
            drain_cnt <= 2'd0;
        end else begin
            state     <= state_d;
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 2'd1 : 2'd0;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        unique case (state)
            ST_RUN:    if (halt_go) state_d = ST_DRAIN;
            ST_DRAIN:  if (drain_cnt == DRAIN_LAST) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // Output logic; front-end controls stay quiet while reset is held
    always_comb begin
        stall       = 1'b0;
        flush_if_id = 1'b0;
        halted      = 1'b0;
        unique case (state)
            ST_RUN: begin
                flush_if_id = reset & (redirect_go | halt_go);
                stall       = reset & load_use & ~redirect_go & ~halt_go;
            end
            ST_DRAIN: begin
                stall = reset;
            end
            ST_HALTED: begin
                stall  = reset;
                halted = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // EX issue register plus MEM/WB occupancy tracking; anything not issuing is a bubble
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_rd     <= '0;
            fwd_a     <= FWD_RF;
            fwd_b     <= FWD_RF;
            mem_valid <= 1'b0;
            mem_wb    <= 1'b0;
            mem_rd    <= '0;
            wb_valid  <= 1'b0;
            wb_wb     <= 1'b0;
            wb_rd     <= '0;
        end else begin
            ex_valid  <= issue;
            ex_ctrl   <= issue ? id_ctrl  : '0;
            ex_rd     <= issue ? id_rd    : '0;
            fwd_a     <= issue ? hd_fwd_a : FWD_RF;
            fwd_b     <= issue ? hd_fwd_b : FWD_RF;
            mem_valid <= ex_valid;
            mem_wb    <= ex_ctrl[CTRL_WB_ENABLE];
            mem_rd    <= ex_rd;
            wb_valid  <= mem_valid;
            wb_wb     <= mem_wb;
            wb_rd     <= mem_rd;
        end
    end

    // Once halted, both MEM and WB must have drained of register writes
    assign pending_write = writes_reg(mem_valid, mem_wb, mem_rd, mem_rd) |
                           writes_reg(wb_valid,  wb_wb,  wb_rd,  wb_rd);

    always @(posedge clk) begin
        if (reset && state == ST_HALTED) assert (!pending_write);
    end

endmodule

// File: tb/tb_id_ex_control.sv
module tb_id_ex_control;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [9:0] id_ctrl;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_redirect, ex_halt_req;
    logic       stall, flush_if_id, ex_valid, halted;
    logic [9:0] ex_ctrl;
    logic [4:0] ex_rd;
    logic [1:0] fwd_a, fwd_b;

    always #5 clk = ~clk;

    id_ex_control dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_redirect(ex_redirect), .ex_halt_req(ex_halt_req),
        .stall(stall), .flush_if_id(flush_if_id), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted)
    );

    // Control templates: {wb,mem_en,mem_wr,op1_pc,op2_imm,ecall,rs2_used,fwdable,branch,rd_to_pc}
    localparam bit [9:0] C_LOAD   = 10'b1100000000;
    localparam bit [9:0] C_ALU_RR = 10'b1000001100;
    localparam bit [9:0] C_ALU_RI = 10'b1000100100;
    localparam bit [9:0] C_ECALL  = 10'b0000010000;

    typedef struct {
        bit       v;
        bit [9:0] ctrl;
        bit [4:0] rd;
    } slot_t;

    // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB
    slot_t    pipe[3];
    bit [1:0] m_fwd_a, m_fwd_b;
    int       halt_age;   // -1 running; cycles since the halting ECALL left EX otherwise
    int       n_cmp = 0;
    int       n_bad = 0;
    logic     smp_stall, smp_flush, smp_halted;
    bit [4:0] reg_pool[5] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd17};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit produces(slot_t s, bit [4:0] r);
        return s.v && s.ctrl[9] && (s.rd != 5'd0) && (s.rd == r);
    endfunction

    function automatic bit [1:0] src_of(bit used, bit [4:0] r, slot_t ex_s, slot_t mem_s);
        if (!used) return 2'd0;
        if (produces(ex_s, r)) return 2'd1;
        if (produces(mem_s, r)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) pipe[k] = '{1'b0, 10'd0, 5'd0};
        m_fwd_a  = 2'd0;
        m_fwd_b  = 2'd0;
        halt_age = -1;
    endtask

    task automatic drive(input bit v, input bit [9:0] c, input bit [4:0] r1, input bit [4:0] r2,
                         input bit [4:0] rd, input bit redir, input bit hreq);
        id_valid = v; id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        ex_redirect = redir; ex_halt_req = hreq;
    endtask

    // Check one cycle at the falling edge, advance the model, land 1 unit after the rising edge
    task automatic step();
        bit       run, used_a, used_b, hz, halt_go, e_flush, e_stall, issue;
        bit [4:0] ra;
        bit [1:0] na, nb;
        @(negedge clk);
        run     = (halt_age < 0);
        used_a  = id_valid && (id_ctrl[4] || !id_ctrl[6]);
        ra      = id_ctrl[4] ? 5'd17 : id_rs1;
        used_b  = id_valid && id_ctrl[3];
        hz      = ((used_a && produces(pipe[0], ra)) || (used_b && produces(pipe[0], id_rs2)))
                  && !pipe[0].ctrl[2];
        halt_go = run && pipe[0].v && pipe[0].ctrl[4] && ex_halt_req;
        e_flush = run && (ex_redirect || halt_go);
        e_stall = !run || (hz && !e_flush);
        smp_stall = stall; smp_flush = flush_if_id; smp_halted = halted;
        chk("stall",    32'(stall),       32'(e_stall));
        chk("flush",    32'(flush_if_id), 32'(e_flush));
        chk("halted",   32'(halted),      32'(halt_age >= 2));
        chk("ex_valid", 32'(ex_valid),    32'(pipe[0].v));
        chk("ex_ctrl",  32'(ex_ctrl),     32'(pipe[0].ctrl));
        chk("ex_rd",    32'(ex_rd),       32'(pipe[0].rd));
        chk("fwd_a",    32'(fwd_a),       32'(m_fwd_a));
        chk("fwd_b",    32'(fwd_b),       32'(m_fwd_b));
        issue = run && !e_flush && !hz && id_valid;
        na = src_of(used_a, ra, pipe[0], pipe[1]);
        nb = src_of(used_b, id_rs2, pipe[0], pipe[1]);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (issue) begin
            pipe[0] = '{1'b1, id_ctrl, id_rd};
            m_fwd_a = na;
            m_fwd_b = nb;
        end else begin
            pipe[0] = '{1'b0, 10'd0, 5'd0};
            m_fwd_a = 2'd0;
            m_fwd_b = 2'd0;
        end
        if (halt_go) halt_age = 0;
        else if (halt_age >= 0) halt_age++;
        @(posedge clk);
        #1;
    endtask

    // Reset with a redirect and a live ID instruction present, to show both are masked
    task automatic do_reset();
        reset = 1'b0;
        drive(1'b1, C_LOAD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        #2;
        chk("rst_stall",    32'(stall),       32'd0);
        chk("rst_flush",    32'(flush_if_id), 32'd0);
        chk("rst_halted",   32'(halted),      32'd0);
        chk("rst_ex_valid", 32'(ex_valid),    32'd0);
        chk("rst_ex_ctrl",  32'(ex_ctrl),     32'd0);
        chk("rst_ex_rd",    32'(ex_rd),       32'd0);
        chk("rst_fwd_a",    32'(fwd_a),       32'd0);
        chk("rst_fwd_b",    32'(fwd_b),       32'd0);
        model_clear();
        @(posedge clk);
        #1;
        chk("rst_hold_ex_valid", 32'(ex_valid), 32'd0);
        reset = 1'b1;
        drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset();

        // Load x5 then dependent add: one stall, then issue with WB forward
        drive(1'b1, C_LOAD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0); step();
        chk("load_issue", 32'(ex_valid), 32'd1);
        drive(1'b1, C_ALU_RR, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0); step();
        chk("lu_stall",  32'(smp_stall), 32'd1);
        chk("lu_bubble", 32'(ex_valid),  32'd0);
        step();
        chk("lu_release", 32'(smp_stall), 32'd0);
        chk("lu_issue",   32'(ex_valid),  32'd1);
        chk("lu_fwd_a",   32'(fwd_a),     32'd2);
        chk("lu_fwd_b",   32'(fwd_b),     32'd0);

        // Back-to-back ALU dependency forwards from MEM
        drive(1'b1, C_ALU_RI, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0); step();
        drive(1'b1, C_ALU_RR, 5'd3, 5'd3, 5'd4, 1'b0, 1'b0); step();
        chk("b2b_stall", 32'(smp_stall), 32'd0);
        chk("b2b_fwd_a", 32'(fwd_a),     32'd1);
        chk("b2b_fwd_b", 32'(fwd_b),     32'd1);

        // One unrelated instruction in between: forward from WB
        drive(1'b1, C_ALU_RI, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0); step();
        drive(1'b1, C_ALU_RI, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0); step();
        drive(1'b1, C_ALU_RR, 5'd3, 5'd3, 5'd4, 1'b0, 1'b0); step();
        chk("gap_fwd_a", 32'(fwd_a), 32'd2);
        chk("gap_fwd_b", 32'(fwd_b), 32'd2);

        // Load to x0 never creates a dependency
        drive(1'b1, C_LOAD, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0); step();
        drive(1'b1, C_ALU_RR, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0); step();
        chk("x0_stall", 32'(smp_stall), 32'd0);
        chk("x0_fwd_a", 32'(fwd_a),     32'd0);
        chk("x0_fwd_b", 32'(fwd_b),     32'd0);

        // Redirect beats load-use
        drive(1'b1, C_LOAD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0); step();
        drive(1'b1, C_ALU_RR, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0); step();
        chk("rd_flush",  32'(smp_flush), 32'd1);
        chk("rd_stall",  32'(smp_stall), 32'd0);
        chk("rd_bubble", 32'(ex_valid),  32'd0);
        chk("rd_ctrl",   32'(ex_ctrl),   32'd0);

        // ECALL halt: flush, two drain cycles, then halted and sticky
        drive(1'b1, C_ECALL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); step();
        drive(1'b1, C_ALU_RR, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1); step();
        chk("halt_flush",  32'(smp_flush), 32'd1);
        chk("halt_bubble", 32'(ex_valid),  32'd0);
        drive(1'b1, C_ALU_RR, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0); step();
        chk("drain1_stall",  32'(smp_stall),  32'd1);
        chk("drain1_halted", 32'(smp_halted), 32'd0);
        step();
        chk("drain2_stall",  32'(smp_stall),  32'd1);
        chk("drain2_halted", 32'(smp_halted), 32'd0);
        step();
        chk("halted_set",   32'(smp_halted), 32'd1);
        chk("halted_stall", 32'(smp_stall),  32'd1);
        drive(1'b1, C_ALU_RR, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0); step();
        chk("halted_held",   32'(smp_halted), 32'd1);
        chk("halted_noflsh", 32'(smp_flush),  32'd0);

        // Reset in the middle of DRAIN
        do_reset();
        drive(1'b1, C_ECALL, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); step();
        drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); step();
        drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); step();
        chk("mid_drain_stall", 32'(smp_stall), 32'd1);
        do_reset();
        drive(1'b1, C_ALU_RI, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0);
        repeat (4) step();
        chk("post_rst_halted", 32'(smp_halted), 32'd0);
        chk("post_rst_issue",  32'(ex_valid),   32'd1);

        // Randomized traffic over a small register pool to provoke hazards
        for (int i = 0; i < 3000; i++) begin
            bit [9:0] c;
            if (halt_age >= 4 || $urandom_range(0, 199) == 0) do_reset();
            case ($urandom_range(0, 5))
                0:       c = C_LOAD;
                1:       c = C_ALU_RR;
                2:       c = C_ALU_RI;
                3:       c = C_ECALL;
                default: c = 10'($urandom_range(0, 1023));
            endcase
            drive($urandom_range(0, 7) != 0, c,
                  reg_pool[$urandom_range(0, 4)], reg_pool[$urandom_range(0, 4)],
                  reg_pool[$urandom_range(0, 4)],
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_control.md
ID_EX_CONTROL -- requirements
Module: id_ex_control

Interface
REQ-001 The block SHALL have these ports (name direction width meaning), one clock; reset is asynchronous and active-low:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  10  decoded control {wb_enable, mem_enable, mem_write, op1_pc, op2_imm, is_ecall, rs2_used, ex_forwardable, is_branch, is_rd_to_pc}
- id_rs1, id_rs2, id_rd  in  5 each  register indices of the ID instruction
- ex_redirect  in  1  EX resolved a control-flow change (mispredict/jump)
- ex_halt_req  in  1  ECALL in EX found halt condition (x17 == 10)
- stall  out  1  hold PC and IF/ID
- flush_if_id  out  1  turn IF/ID into a bubble
- ex_ctrl  out  10  registered control for EX (same field order)
- ex_rd  out  5  registered destination
- ex_valid  out  1  EX holds a real instruction
- fwd_a, fwd_b  out  2 each  registered operand select: 0 regfile, 1 from MEM, 2 from WB
- halted  out  1  processor halted

Function
REQ-002 The block SHALL track rd/wb_enable/valid for EX, MEM and WB in internal registers, advancing one stage per cycle (MEM/WB never stall).
REQ-003 A write match SHALL require stage valid, wb_enable=1 and rd != 0.
REQ-004 ID SHALL read rs1 when op1_pc=0, rs2 when rs2_used=1, and x17 (as rs1) when is_ecall=1.
REQ-005 Load-use hazard SHALL be declared when EX matches a read register of ID and EX ex_forwardable=0.
REQ-006 On hazard (no redirect): stall=1 for that cycle, EX loads a bubble (ex_valid=0, ex_ctrl=0, ex_rd=0); the ID instruction re-evaluates next cycle and then issues.
REQ-007 On ex_redirect=1: flush_if_id=1, EX loads a bubble, stall=0; redirect SHALL take priority over load-use stall.
REQ-008 Normal issue SHALL register id_ctrl, id_rd, id_valid into EX; when id_valid=0 the EX stage SHALL be a bubble.
REQ-009 fwd_a/fwd_b SHALL be computed for the issuing instruction against the stages it will meet one cycle later: 1 if the current EX (becoming MEM) matches, else 2 if current MEM (becoming WB) matches, else 0; MEM has priority over WB; selects SHALL be 0 for unused operands and bubbles.
REQ-010 Halt FSM states RUN, DRAIN, HALTED; RUN->DRAIN when ex_valid=1, ex_ctrl.is_ecall=1, ex_halt_req=1.
REQ-011 Entering DRAIN SHALL flush (flush_if_id=1, EX bubble) so no younger instruction retires.
REQ-012 DRAIN SHALL last exactly 2 cycles (2-bit counter) letting older MEM/WB instructions retire, then enter HALTED.
REQ-013 In DRAIN and HALTED: stall=1, EX loads bubbles; HALTED is terminal until reset; halted=1 only in HALTED.
REQ-014 ex_redirect or hazard during DRAIN/HALTED SHALL be ignored.

Reset
REQ-015 While reset=0 all pipeline state SHALL clear asynchronously: ex_ctrl=0, ex_rd=0, ex_valid=0, fwd_a=fwd_b=0, MEM/WB tracking invalid, FSM=RUN, counter=0.
REQ-016 During reset stall=0, flush_if_id=0, halted=0; first issue occurs on the first rising edge after release.
REQ-017 Reset asserted mid-DRAIN SHALL return to RUN with no halt.

Structure
REQ-018 Control-field bit positions, forward-select encodings (FWD_RF, FWD_MEM, FWD_WB) and FSM state encodings SHALL live in the shared definitions file alongside the opcode defines.
REQ-019 Hazard and forward-select comparison SHALL be one sub-module, hazard_detect (purely combinational); registers and FSM remain in id_ex_control.

Verification
REQ-020 Load then dependent add: EX=load rd=x5, ID=add rs1=x5 -> stall=1 one cycle, ex_valid=0; next cycle add issues with fwd_a=2.
REQ-021 Back-to-back ALU: addi x3 then add x4,x3,x3 -> no stall, fwd_a=fwd_b=1; with one unrelated instruction between -> fwd=2.
REQ-022 Write to x0: EX=addi x0, ID reads x0 -> fwd_a=0, no stall.
REQ-023 Redirect and hazard same cycle -> flush_if_id=1, stall=0, EX bubble.
REQ-024 ECALL in EX with ex_halt_req=1 -> flush that cycle, stall=1 for 2 DRAIN cycles, halted=1 on third cycle and held.
REQ-025 Assert reset during DRAIN -> all outputs zero, FSM RUN, halted never asserts.
